axi_interconnect_crossbar_mresp_route: RTL and testbench

Response-path router for one master port of the AXI crossbar. It takes the slave-index-tagged response stream (R or B) returned by the downstream master side and steers each beat back to the originating slave port through a per-slave one-entry output register. It keeps a per-slave outstanding-transaction count so the request side can throttle new issues. It sits opposite the slave-request arbiter that packs `{info, sid}` onto the master port.

---
 rtl/axi_interconnect_crossbar_mresp_route.sv | 138 +++++++++++++
 tb/tb_axi_interconnect_crossbar_mresp_route.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_interconnect_crossbar_mresp_route.sv
// Response-path router: steers sid-tagged R/B beats into per-slave one-entry output
// registers and keeps a per-slave outstanding-transaction count for request throttling.
module axi_interconnect_crossbar_mresp_route_slot #(
  parameter int MODE_READ       = 1,
  parameter int WIDTH_RESPINFO  = 48,
  parameter int NUM_OUTSTANDING = 4,
  parameter int WIDTH_CNT       = 3
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [WIDTH_RESPINFO-1:0] payload,
  input  logic                      s_ready,
  input  logic                      issue,
  output logic                      s_valid,
  output logic [WIDTH_RESPINFO-1:0] s_info,
  output logic                      full,
  output logic                      cnt_err
);
  logic                      valid_d, valid_q;
  logic [WIDTH_RESPINFO-1:0] info_d, info_q;
  logic [WIDTH_CNT-1:0]      cnt_d, cnt_q;
  logic                      full_d, full_q;
  logic                      cmpl;

  always_comb begin
    cmpl    = load & ((MODE_READ == 0) | payload[WIDTH_RESPINFO-1]);
    // a load in the same cycle as a drain wins, so valid stays high
    valid_d = load | (valid_q & ~s_ready);
    info_d  = load ? payload : info_q;
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    if (issue && !cmpl) begin
      if (cnt_q == WIDTH_CNT'(NUM_OUTSTANDING)) cnt_err = 1'b1;
      else                                      cnt_d   = cnt_q + 1'b1;
    end else if (cmpl && !issue) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
    full_d = (cnt_d == WIDTH_CNT'(NUM_OUTSTANDING));
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      info_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign s_valid = valid_q;
  assign s_info  = info_q;
  assign full    = full_q;
endmodule

module axi_interconnect_crossbar_mresp_route #(
  parameter int MODE_READ       = 1,
  parameter int NUM_SLAVE       = 1,
  parameter int WIDTH_RESPINFO  = 48,
  parameter int NUM_OUTSTANDING = 4,
  parameter int WIDTH_SALVE     = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1,
  parameter int WIDTH_CNT       = $clog2(NUM_OUTSTANDING + 1),
  parameter int U_DLY           = 1
) (
  input  logic                                clk_sys,
  input  logic                                rst_n,
  input  logic                                addr_issue,
  input  logic [WIDTH_SALVE-1:0]              addr_issue_sid,
  input  logic [WIDTH_RESPINFO+WIDTH_SALVE-1:0] m_resp_info,
  input  logic                                m_resp_valid,
  output logic                                m_resp_ready,
  output logic [NUM_SLAVE*WIDTH_RESPINFO-1:0] s_resp_info,
  output logic [NUM_SLAVE-1:0]                s_resp_valid,
  input  logic [NUM_SLAVE-1:0]                s_resp_ready,
  output logic [NUM_SLAVE-1:0]                s_outstanding_full,
  output logic                                err_unexpected
);
  logic [WIDTH_SALVE-1:0]    sid;
  logic [WIDTH_RESPINFO-1:0] payload;
  logic                      sid_ok, isid_ok, accept;
  logic [NUM_SLAVE-1:0]      load, issue, slot_err;
  logic                      err_d, err_q;

  assign sid     = m_resp_info[WIDTH_SALVE-1:0];
  assign payload = m_resp_info[WIDTH_SALVE +: WIDTH_RESPINFO];
  assign sid_ok  = (32'(sid) < 32'(NUM_SLAVE));
  assign isid_ok = (32'(addr_issue_sid) < 32'(NUM_SLAVE));

  always_comb begin
    m_resp_ready = 1'b0;
    issue        = '0;
    load         = '0;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      if (sid == WIDTH_SALVE'(i)) m_resp_ready = ~s_resp_valid[i] | s_resp_ready[i];
      if (addr_issue && addr_issue_sid == WIDTH_SALVE'(i)) issue[i] = 1'b1;
    end
    // unroutable beats are swallowed so they never wedge the master port
    if (!sid_ok) m_resp_ready = 1'b1;
    m_resp_ready = m_resp_ready & rst_n;
    accept       = m_resp_valid & m_resp_ready;
    for (int i = 0; i < NUM_SLAVE; i++)
      load[i] = accept & (sid == WIDTH_SALVE'(i));
    err_d = err_q | (accept & ~sid_ok) | (addr_issue & ~isid_ok) | (|slot_err);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_unexpected = err_q;

  for (genvar g = 0; g < NUM_SLAVE; g++) begin : g_slot
    axi_interconnect_crossbar_mresp_route_slot #(
      .MODE_READ      (MODE_READ),
      .WIDTH_RESPINFO (WIDTH_RESPINFO),
      .NUM_OUTSTANDING(NUM_OUTSTANDING),
      .WIDTH_CNT      (WIDTH_CNT)
    ) u_slot (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .load    (load[g]),
      .payload (payload),
      .s_ready (s_resp_ready[g]),
      .issue   (issue[g]),
      .s_valid (s_resp_valid[g]),
      .s_info  (s_resp_info[g*WIDTH_RESPINFO +: WIDTH_RESPINFO]),
      .full    (s_outstanding_full[g]),
      .cnt_err (slot_err[g])
    );
  end
endmodule

// File: tb/tb_axi_interconnect_crossbar_mresp_route.sv
// Bench: read-mode 4-slave instance (directed + randomized vs. queue model) and
// write-mode 3-slave instance (table-driven vectors).
module tb_axi_interconnect_crossbar_mresp_route;
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  logic       a_issue, a_mv, a_mrdy, a_err;
  logic [1:0] a_isid;
  logic [9:0] a_minfo;
  logic [31:0] a_sinfo;
  logic [3:0] a_svld, a_srdy, a_full;

  logic       b_issue, b_mv, b_mrdy, b_err;
  logic [1:0] b_isid;
  logic [9:0] b_minfo;
  logic [23:0] b_sinfo;
  logic [2:0] b_svld, b_srdy, b_full;

  axi_interconnect_crossbar_mresp_route #(
    .MODE_READ(1), .NUM_SLAVE(4), .WIDTH_RESPINFO(8), .NUM_OUTSTANDING(4)
  ) u_dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .addr_issue(a_issue), .addr_issue_sid(a_isid),
    .m_resp_info(a_minfo), .m_resp_valid(a_mv), .m_resp_ready(a_mrdy),
    .s_resp_info(a_sinfo), .s_resp_valid(a_svld), .s_resp_ready(a_srdy),
    .s_outstanding_full(a_full), .err_unexpected(a_err)
  );

  axi_interconnect_crossbar_mresp_route #(
    .MODE_READ(0), .NUM_SLAVE(3), .WIDTH_RESPINFO(8), .NUM_OUTSTANDING(4)
  ) u_dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .addr_issue(b_issue), .addr_issue_sid(b_isid),
    .m_resp_info(b_minfo), .m_resp_valid(b_mv), .m_resp_ready(b_mrdy),
    .s_resp_info(b_sinfo), .s_resp_valid(b_svld), .s_resp_ready(b_srdy),
    .s_outstanding_full(b_full), .err_unexpected(b_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic issue; logic [1:0] isid; logic mv; logic [1:0] sid; logic [7:0] pay; logic [2:0] srdy;
    logic rdy; logic [2:0] vld; logic [2:0] full; logic err; logic [7:0] info0;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(logic iss, logic [1:0] isid, logic mv, logic [1:0] sid,
                              logic [7:0] pay, logic [2:0] srdy, logic rdy, logic [2:0] vld,
                              logic [2:0] full, logic err, logic [7:0] info0);
    vec_t v;
    v.issue = iss; v.isid = isid; v.mv = mv; v.sid = sid; v.pay = pay; v.srdy = srdy;
    v.rdy = rdy; v.vld = vld; v.full = full; v.err = err; v.info0 = info0;
    return v;
  endfunction

  task automatic drive_a(input logic iss, input logic [1:0] isid, input logic mv,
                         input logic [1:0] sid, input logic [7:0] pay, input logic [3:0] srdy);
    @(negedge clk_sys);
    a_issue = iss; a_isid = isid; a_mv = mv; a_minfo = {pay, sid}; a_srdy = srdy;
  endtask

  task automatic pulse_reset();
    @(negedge clk_sys);
    a_issue = 1'b0; a_mv = 1'b0; a_srdy = '0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] bp[4] = '{8'h01, 8'h02, 8'h03, 8'h84};
  logic [7:0] sq[4][$];
  int cnt[4];
  logic merr, held, prdy, acc, inc, dec;
  int sid;
  logic [7:0] pay;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_issue = 0; a_isid = 0; a_mv = 0; a_minfo = '0; a_srdy = '0;
    b_issue = 0; b_isid = 0; b_mv = 0; b_minfo = '0; b_srdy = '0;
    #12;
    chk("rst_a_outs", {a_svld, a_full, a_err, a_mrdy}, '0);
    chk("rst_a_info", a_sinfo, '0);
    chk("rst_b_outs", {b_svld, b_full, b_err, b_mrdy}, '0);
    @(negedge clk_sys); rst_n = 1'b1;

    // write-mode table: fill to full, issue+completion, backpressure hold, drain, errors
    tbl[0]  = mk(1,0, 0,0,8'h00,3'b111, 1,3'b000,3'b000,0,8'h00);
    tbl[1]  = mk(1,0, 0,0,8'h00,3'b111, 1,3'b000,3'b000,0,8'h00);
    tbl[2]  = mk(1,0, 0,0,8'h00,3'b111, 1,3'b000,3'b000,0,8'h00);
    tbl[3]  = mk(1,0, 0,0,8'h00,3'b111, 1,3'b000,3'b001,0,8'h00);
    tbl[4]  = mk(1,0, 1,0,8'h11,3'b111, 1,3'b001,3'b001,0,8'h11);
    tbl[5]  = mk(0,0, 1,0,8'h22,3'b111, 1,3'b001,3'b000,0,8'h22);
    tbl[6]  = mk(0,0, 1,0,8'h33,3'b110, 0,3'b001,3'b000,0,8'h22);
    tbl[7]  = mk(0,0, 1,0,8'h33,3'b111, 1,3'b001,3'b000,0,8'h33);
    tbl[8]  = mk(0,0, 1,0,8'h44,3'b111, 1,3'b001,3'b000,0,8'h44);
    tbl[9]  = mk(0,0, 1,0,8'h55,3'b111, 1,3'b001,3'b000,0,8'h55);
    tbl[10] = mk(0,0, 0,0,8'h00,3'b111, 1,3'b000,3'b000,0,8'h55);
    tbl[11] = mk(0,0, 1,3,8'h66,3'b111, 1,3'b000,3'b000,1,8'h55);
    tbl[12] = mk(0,0, 1,1,8'h77,3'b111, 1,3'b010,3'b000,1,8'h55);
    tbl[13] = mk(0,0, 0,1,8'h00,3'b000, 0,3'b010,3'b000,1,8'h55);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk_sys);
      b_issue = tbl[k].issue; b_isid = tbl[k].isid; b_mv = tbl[k].mv;
      b_minfo = {tbl[k].pay, tbl[k].sid}; b_srdy = tbl[k].srdy;
      #1 chk($sformatf("tbl%0d_rdy", k), b_mrdy, tbl[k].rdy);
      @(posedge clk_sys); #1;
      chk($sformatf("tbl%0d_vld", k), b_svld, tbl[k].vld);
      chk($sformatf("tbl%0d_full", k), b_full, tbl[k].full);
      chk($sformatf("tbl%0d_err", k), b_err, tbl[k].err);
      chk($sformatf("tbl%0d_info0", k), b_sinfo[7:0], tbl[k].info0);
    end
    @(negedge clk_sys); b_issue = 0; b_mv = 0;

    // read burst to slave 2, rlast on beat 4
    drive_a(1, 2, 0, 0, 8'h00, 4'hF);
    for (int b = 0; b < 4; b++) begin
      drive_a(0, 0, 1, 2, bp[b], 4'hF);
      #1 chk("burst_rdy", a_mrdy, 1);
      @(posedge clk_sys); #1;
      chk("burst_vld", a_svld, 4'b0100);
      chk("burst_info", a_sinfo[23:16], bp[b]);
      chk("burst_err", a_err, 0);
    end
    drive_a(0, 0, 0, 2, 8'h00, 4'hF);
    @(posedge clk_sys); #1;
    chk("burst_idle_vld", a_svld, 4'b0000);
    chk("burst_cnt_zero_err", a_err, 0);
    drive_a(0, 0, 1, 2, 8'h85, 4'h0);
    @(posedge clk_sys); #1;
    chk("underflow_delivered", a_svld, 4'b0100);
    chk("underflow_err", a_err, 1);
    drive_a(0, 0, 0, 2, 8'h00, 4'h0);
    @(posedge clk_sys); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", a_svld, 0);
    chk("async_rst_info", a_sinfo, 0);
    chk("async_rst_err", a_err, 0);
    chk("async_rst_rdy", a_mrdy, 0);
    rst_n = 1'b1;

    // outstanding counter saturation on slave 1
    for (int n = 0; n < 4; n++) begin
      drive_a(1, 1, 0, 0, 8'h00, 4'hF);
      @(posedge clk_sys); #1;
    end
    chk("cnt_full", a_full, 4'b0010);
    drive_a(1, 1, 1, 1, 8'h80, 4'hF);
    @(posedge clk_sys); #1;
    chk("cnt_iss_cmpl_full", a_full, 4'b0010);
    chk("cnt_iss_cmpl_err", a_err, 0);
    drive_a(1, 1, 0, 1, 8'h00, 4'hF);
    @(posedge clk_sys); #1;
    chk("cnt_overflow_err", a_err, 1);
    chk("cnt_overflow_full", a_full, 4'b0010);
    pulse_reset();

    // backpressure on slave 1, no bubble on release
    drive_a(0, 0, 1, 1, 8'hA1, 4'b1101);
    #1 chk("bp_first_rdy", a_mrdy, 1);
    drive_a(0, 0, 1, 1, 8'hA2, 4'b1101);
    #1 chk("bp_stall_rdy", a_mrdy, 0);
    @(posedge clk_sys); #1;
    chk("bp_hold_info", a_sinfo[15:8], 8'hA1);
    chk("bp_hold_vld", a_svld, 4'b0010);
    drive_a(0, 0, 1, 1, 8'hA2, 4'b1111);
    #1 chk("bp_release_rdy", a_mrdy, 1);
    @(posedge clk_sys); #1;
    chk("bp_release_info", a_sinfo[15:8], 8'hA2);
    chk("bp_release_vld", a_svld, 4'b0010);
    pulse_reset();

    // randomized traffic against a per-slave queue/counter model
    for (int i = 0; i < 4; i++) begin sq[i].delete(); cnt[i] = 0; end
    merr = 0; held = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      for (int i = 0; i < 4; i++) begin
        chk("rnd_vld", a_svld[i], sq[i].size() != 0);
        if (sq[i].size() != 0) chk("rnd_info", a_sinfo[i*8 +: 8], sq[i][0]);
        chk("rnd_full", a_full[i], cnt[i] == 4);
      end
      chk("rnd_err", a_err, merr);
      if (c % 250 == 249) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin sq[i].delete(); cnt[i] = 0; end
        merr = 0; held = 0;
      end
      if (!held) begin
        a_mv    = ($urandom_range(0, 3) != 0);
        a_minfo = {($urandom_range(0, 2) == 0), 7'($urandom), 2'($urandom)};
      end
      a_srdy  = 4'($urandom) | 4'($urandom);
      a_issue = ($urandom_range(0, 3) == 0);
      a_isid  = 2'($urandom);
      #1;
      sid  = int'(a_minfo[1:0]);
      pay  = a_minfo[9:2];
      prdy = (sq[sid].size() == 0) || a_srdy[sid];
      chk("rnd_rdy", a_mrdy, prdy);
      acc  = a_mv && prdy;
      held = a_mv && !acc;
      for (int i = 0; i < 4; i++)
        if (a_srdy[i] && sq[i].size() != 0) void'(sq[i].pop_front());
      if (acc) sq[sid].push_back(pay);
      for (int i = 0; i < 4; i++) begin
        inc = a_issue && (int'(a_isid) == i);
        dec = acc && (sid == i) && pay[7];
        if (inc && !dec) begin
          if (cnt[i] == 4) merr = 1; else cnt[i]++;
        end else if (dec && !inc) begin
          if (cnt[i] == 0) merr = 1; else cnt[i]--;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
